pmu_jtag_driver: RTL and testbench



---
 rtl/pmu_jtag_pkg.sv | 52 +++++
 rtl/pmu_jtag_tck_gen.sv | 39 +++
 rtl/pmu_jtag_driver.sv | 206 ++++++++++++++++++++
 tb/tb_pmu_jtag_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_jtag_pkg.sv
// Shared types and TMS pattern constants for the PMU JTAG initiator.
// Optional response path is enabled by defining PMU_JTAG_DRV_RSP_EN.
package pmu_jtag_pkg;

  localparam int unsigned PAT_W = 6;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IDLE     = 2'd1,
    OP_SHIFT_IR = 2'd2,
    OP_SHIFT_DR = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_RESP  = 3'd4
  } jtag_state_e;

  // TMS patterns are stored LSB first: bit 0 is the first TCK.
  localparam logic [PAT_W-1:0] RESET_TMS  = 6'b01_1111;
  localparam int unsigned      RESET_LEN  = 6;
  localparam logic [PAT_W-1:0] IR_PRE_TMS = 6'b00_0011;
  localparam int unsigned      IR_PRE_LEN = 4;
  localparam logic [PAT_W-1:0] DR_PRE_TMS = 6'b00_0001;
  localparam int unsigned      DR_PRE_LEN = 3;
  localparam logic [PAT_W-1:0] POST_TMS   = 6'b00_0001;
  localparam int unsigned      POST_LEN   = 2;

  // Preamble TMS pattern for an op; RESET is a pure preamble, IDLE has none.
  function automatic logic [PAT_W-1:0] pre_tms(jtag_op_e op);
    case (op)
      OP_RESET:    return RESET_TMS;
      OP_SHIFT_IR: return IR_PRE_TMS;
      OP_SHIFT_DR: return DR_PRE_TMS;
      default:     return '0;
    endcase
  endfunction

  // Index of the last preamble TCK for an op.
  function automatic int unsigned pre_last(jtag_op_e op);
    case (op)
      OP_RESET:    return RESET_LEN - 1;
      OP_SHIFT_IR: return IR_PRE_LEN - 1;
      OP_SHIFT_DR: return DR_PRE_LEN - 1;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/pmu_jtag_tck_gen.sv
// TCK generator: divides clk by 2*CLK_DIV while enabled and flags the
// clk edge on which TCK will rise or fall.
module pmu_jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             half_done_c;

  assign half_done_c = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_tick_c = half_done_c && !tck_o;
  assign fall_tick_c = half_done_c && tck_o;

  // Half-period counter; TCK parks low whenever the generator is idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (half_done_c) begin
      cnt_q <= '0;
      tck_o <= ~tck_o;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pmu_jtag_driver.sv
// Host-side JTAG initiator for the PMU test port: turns word-level
// commands into TMS/TDI sequences and captures TDO during shifts.
// Define PMU_JTAG_DRV_RSP_EN to build the TDO capture and response path.
module pmu_jtag_driver
  import pmu_jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [4:0]        cmd_len_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  output logic              busy_o
);

  localparam int unsigned LEN_W = $clog2(DATA_W + 1);

  jtag_state_e       state_q;
  jtag_op_e          op_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [PAT_W-1:0]  pat_q;

  logic              rise_tick_c;
  logic              fall_tick_c;
  logic              phase_end_c;
  logic              next_last_c;
  logic [PAT_W-1:0]  acc_pat_c;
  jtag_op_e          acc_op_c;

  pmu_jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (busy_o),
    .tck_o      (tck_o),
    .rise_tick_c(rise_tick_c),
    .fall_tick_c(fall_tick_c)
  );

  // Decode of the incoming op and of phase boundaries for the sequencer.
  always_comb begin
    acc_op_c    = jtag_op_e'(cmd_op_i);
    acc_pat_c   = pre_tms(acc_op_c);
    next_last_c = (idx_q + LEN_W'(2)) == len_q;
    phase_end_c = 1'b0;
    case (state_q)
      ST_PRE:   phase_end_c = (idx_q == LEN_W'(pre_last(op_q)));
      ST_SHIFT: phase_end_c = (idx_q == (len_q - LEN_W'(1)));
      ST_POST:  phase_end_c = (idx_q == LEN_W'(POST_LEN - 1));
      default:  phase_end_c = 1'b0;
    endcase
  end

`ifdef PMU_JTAG_DRV_RSP_EN
  logic [DATA_W-1:0] cap_q;

  // TDO capture: shift in from the top on each shift-bit TCK rising edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_q <= '0;
    end else if ((state_q == ST_SHIFT) && rise_tick_c) begin
      cap_q <= {tdo_i, cap_q[DATA_W-1:1]};
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp  = ^{rsp_ready_i, tdo_i, rise_tick_c};
  assign rsp_valid_o = 1'b0;
  assign rsp_data_o  = '0;
`endif

  // Sequencer: each TCK falling edge loads the next TCK's TMS/TDI.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      pat_q       <= '0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      busy_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
`ifdef PMU_JTAG_DRV_RSP_EN
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op_q        <= acc_op_c;
            len_q       <= (cmd_len_i == '0) ? LEN_W'(DATA_W) : LEN_W'(cmd_len_i);
            idx_q       <= '0;
            pat_q       <= acc_pat_c;
            tms_o       <= acc_pat_c[0];
            tdi_o       <= 1'b0;
            busy_o      <= 1'b1;
            cmd_ready_o <= 1'b0;
            if (acc_op_c == OP_IDLE) begin
              state_q <= ST_SHIFT;
              data_q  <= '0;
            end else begin
              state_q <= ST_PRE;
              data_q  <= cmd_data_i;
            end
          end
        end

        ST_PRE: begin
          if (fall_tick_c) begin
            if (!phase_end_c) begin
              idx_q <= idx_q + LEN_W'(1);
              pat_q <= pat_q >> 1;
              tms_o <= pat_q[1];
            end else if (op_q == OP_RESET) begin
              state_q     <= ST_IDLE;
              busy_o      <= 1'b0;
              cmd_ready_o <= 1'b1;
              tdi_o       <= 1'b0;
            end else begin
              state_q <= ST_SHIFT;
              idx_q   <= '0;
              tms_o   <= (len_q == LEN_W'(1));
              tdi_o   <= data_q[0];
            end
          end
        end

        ST_SHIFT: begin
          if (fall_tick_c) begin
            if (!phase_end_c) begin
              idx_q  <= idx_q + LEN_W'(1);
              data_q <= data_q >> 1;
              tdi_o  <= data_q[1];
              tms_o  <= (op_q != OP_IDLE) && next_last_c;
            end else if (op_q == OP_IDLE) begin
              state_q     <= ST_IDLE;
              busy_o      <= 1'b0;
              cmd_ready_o <= 1'b1;
              tdi_o       <= 1'b0;
            end else begin
              state_q <= ST_POST;
              idx_q   <= '0;
              pat_q   <= POST_TMS;
              tms_o   <= POST_TMS[0];
              tdi_o   <= 1'b0;
            end
          end
        end

        ST_POST: begin
          if (fall_tick_c) begin
            if (!phase_end_c) begin
              idx_q <= idx_q + LEN_W'(1);
              pat_q <= pat_q >> 1;
              tms_o <= pat_q[1];
            end else begin
              busy_o <= 1'b0;
`ifdef PMU_JTAG_DRV_RSP_EN
              state_q     <= ST_RESP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= cap_q >> (LEN_W'(DATA_W) - len_q);
`else
              state_q     <= ST_IDLE;
              cmd_ready_o <= 1'b1;
`endif
            end
          end
        end

`ifdef PMU_JTAG_DRV_RSP_EN
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
`endif

        default: begin
          state_q     <= ST_IDLE;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_jtag_driver.sv
// Self-checking bench for pmu_jtag_driver: directed table, reset abort,
// and randomized commands against a sequence-level reference model.
module tb_pmu_jtag_driver;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DATA_W  = 32;
`ifdef PMU_JTAG_DRV_RSP_EN
  localparam bit RSP_EN = 1'b1;
`else
  localparam bit RSP_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [4:0]        cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              tck;
  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              busy;

  logic [63:0] tdo_vec;
  bit          tdo_loop;
  int          tck_cnt;
  bit          tms_q[$];
  bit          tdi_q[$];

  int n_chk;
  int n_pass;

  pmu_jtag_driver #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_len_i  (cmd_len),
    .cmd_data_i (cmd_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .tck_o      (tck),
    .tms_o      (tms),
    .tdi_o      (tdi),
    .tdo_i      (tdo),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target model: TDO either echoes TDI or follows a per-TCK bit vector.
  assign tdo = tdo_loop ? tdi : tdo_vec[tck_cnt[5:0]];

  always @(negedge tck) tck_cnt = tck_cnt + 1;

  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: the TMS/TDI sequence a command must produce, one entry per TCK.
  task automatic model(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                       output logic [63:0] tms_v, output logic [63:0] tdi_v,
                       output int n, output int pre);
    bit tq[$];
    bit dq[$];
    logic [5:0] pat;
    int L;
    L = (len == 5'd0) ? 32 : int'(len);
    pre = 0;
    case (op)
      2'd0: begin
        pat = 6'b011111;
        for (int i = 0; i < 6; i++) begin tq.push_back(pat[i]); dq.push_back(1'b0); end
        pre = 6;
      end
      2'd1: begin
        for (int i = 0; i < L; i++) begin tq.push_back(1'b0); dq.push_back(1'b0); end
      end
      default: begin
        if (op == 2'd2) begin pat = 6'b000011; pre = 4; end
        else begin pat = 6'b000001; pre = 3; end
        for (int i = 0; i < pre; i++) begin tq.push_back(pat[i]); dq.push_back(1'b0); end
        for (int i = 0; i < L; i++) begin tq.push_back(i == L - 1); dq.push_back(data[i]); end
        tq.push_back(1'b1); dq.push_back(1'b0);
        tq.push_back(1'b0); dq.push_back(1'b0);
      end
    endcase
    n = tq.size();
    tms_v = '0;
    tdi_v = '0;
    for (int i = 0; i < n; i++) begin tms_v[i] = tq[i]; tdi_v[i] = dq[i]; end
  endtask

  function automatic logic [31:0] model_rsp(input bit loop, input logic [31:0] data,
                                            input logic [63:0] tv, input int pre, input logic [4:0] len);
    logic [63:0] m;
    int L;
    L = (len == 5'd0) ? 32 : int'(len);
    m = (64'd1 << L) - 64'd1;
    if (loop) return data & m[31:0];
    return 32'((tv >> pre) & m);
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    logic [31:0] data;
    bit          loop;
    logic [63:0] tdo;
    int          rdy_dly;
    int          exp_tck;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_cmd(input vec_t v);
    logic [63:0] etms, etdi, atms, atdi;
    int n, pre, c, busy_cnt, first_rise;
    bit want_rsp;
    model(v.op, v.len, v.data, etms, etdi, n, pre);
    c = 0;
    while (!cmd_ready && c < 200) begin @(negedge clk); c++; end
    chk("accept_wait", 64'(cmd_ready), 64'd1);
    tms_q.delete();
    tdi_q.delete();
    tck_cnt   = 0;
    tdo_vec   = v.tdo;
    tdo_loop  = v.loop;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_len   = v.len;
    cmd_data  = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 5'($urandom);
    cmd_data  = $urandom;
    chk("first_cycle_tck_busy_ready", 64'({tck, busy, cmd_ready}), 64'b010);
    c = 1;
    busy_cnt = 0;
    first_rise = 0;
    while (busy && c < 1000) begin
      busy_cnt++;
      if (tck && first_rise == 0) first_rise = c;
      @(negedge clk);
      c++;
    end
    chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_tck * 2 * CLK_DIV));
    chk("first_tck_rise", 64'(first_rise), 64'(CLK_DIV + 1));
    chk("tck_count", 64'(tms_q.size()), 64'(v.exp_tck));
    atms = '0;
    atdi = '0;
    for (int i = 0; i < tms_q.size() && i < 64; i++) begin atms[i] = tms_q[i]; atdi[i] = tdi_q[i]; end
    chk("tms_seq", atms, etms);
    chk("tdi_seq", atdi, etdi);
    want_rsp = RSP_EN && v.op[1];
    chk("end_rsp_valid", 64'(rsp_valid), 64'(want_rsp));
    chk("end_cmd_ready", 64'(cmd_ready), 64'(!want_rsp));
    if (want_rsp) begin
      chk("rsp_data", 64'(rsp_data), 64'(v.exp_rsp));
      for (int k = 0; k < v.rdy_dly; k++) begin
        @(negedge clk);
        chk("rsp_hold", {30'd0, rsp_valid, cmd_ready, rsp_data}, {30'd0, 2'b10, v.exp_rsp});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_release", 64'({rsp_valid, cmd_ready}), 64'b01);
    end
  endtask

  initial begin
    vec_t v;
    int c, seen, n, pre;
    logic [63:0] t1, t2;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_len = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    tdo_vec = '0;
    tdo_loop = 1'b0;
    tck_cnt = 0;

    vecs[0] = '{2'd0, 5'd0, 32'h0,        1'b0, 64'h0,   0,  6,  32'h0};
    vecs[1] = '{2'd3, 5'd8, 32'h0000_00A5, 1'b1, 64'h0,   0,  13, 32'h0000_00A5};
    vecs[2] = '{2'd2, 5'd0, 32'hDEAD_BEEF, 1'b0, '1,      0,  38, 32'hFFFF_FFFF};
    vecs[3] = '{2'd3, 5'd4, 32'h0000_0009, 1'b0, 64'h50,  10, 9,  32'h0000_000A};
    vecs[4] = '{2'd1, 5'd5, 32'hFFFF_FFFF, 1'b0, 64'h0,   0,  5,  32'h0};
    vecs[5] = '{2'd3, 5'd1, 32'h0000_0001, 1'b0, 64'h8,   0,  6,  32'h0000_0001};
    vecs[6] = '{2'd2, 5'd3, 32'h0000_0006, 1'b0, 64'h1F0, 1,  9,  32'h0000_0007};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({tck, tms, tdi, cmd_ready, rsp_valid, busy}), 64'b010100);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", 64'({tck, tms, tdi, cmd_ready, rsp_valid, busy}), 64'b010100);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Abort a SHIFT_DR during its fifth TCK with an asynchronous reset.
    tms_q.delete();
    tdi_q.delete();
    tck_cnt = 0;
    tdo_loop = 1'b1;
    c = 0;
    while (!cmd_ready && c < 200) begin @(negedge clk); c++; end
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_len = 5'd8;
    cmd_data = 32'h0000_00FF;
    @(negedge clk);
    cmd_valid = 1'b0;
    c = 0;
    while (tck_cnt < 4 && c < 200) begin @(negedge clk); c++; end
    chk("abort_reached_tck5", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({tck, tms, tdi, cmd_ready, rsp_valid, busy}), 64'b010100);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid || busy || tck) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    run_cmd(vecs[0]);

    // Randomized commands checked against the sequence model.
    for (int r = 0; r < 30; r++) begin
      v.op      = 2'($urandom_range(0, 3));
      v.len     = 5'($urandom);
      v.data    = $urandom;
      v.loop    = 1'($urandom_range(0, 1));
      v.tdo     = {$urandom, $urandom};
      v.rdy_dly = $urandom_range(0, 3);
      model(v.op, v.len, v.data, t1, t2, n, pre);
      v.exp_tck = n;
      v.exp_rsp = model_rsp(v.loop, v.data, v.tdo, pre, v.len);
      run_cmd(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
